// File: rtl/dab_sequencer.sv
// Start-up / shutdown sequencer for a dual-active-bridge converter: qualifies the DC link,
// ramps the modulation targets in and out, and latches over-voltage faults.
module dab_sequencer #(
    parameter logic        [8:0]  STEP       = 9'd4,
    parameter logic signed [13:0] VMIN_START = 14'sd1000,
    parameter logic signed [13:0] VMAX       = 14'sd7000,
    parameter logic        [3:0]  QUAL       = 4'd8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               fault_clr,
    input  logic               trigger,
    input  logic signed [13:0] Vdc1,
    input  logic signed [13:0] Vdc2,
    input  logic signed [8:0]  tau1_in,
    input  logic signed [8:0]  tau2_in,
    input  logic signed [8:0]  phi_in,
    output logic signed [8:0]  tau1_out,
    output logic signed [8:0]  tau2_out,
    output logic signed [8:0]  phi_out,
    output logic               gate_en,
    output logic [2:0]         state,
    output logic               fault
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitDc   = 3'd1,
        StRamp     = 3'd2,
        StRun      = 3'd3,
        StRampDown = 3'd4,
        StFault    = 3'd5
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;

    // Move cur toward tgt by at most STEP; 10-bit difference cannot overflow or overshoot.
    function automatic logic signed [8:0] step_to(input logic signed [8:0] cur,
                                                  input logic signed [8:0] tgt);
        logic signed [9:0] diff;
        logic signed [9:0] stp;
        stp  = $signed({1'b0, STEP});
        diff = $signed({tgt[8], tgt}) - $signed({cur[8], cur});
        if (diff > stp) begin
            step_to = cur + STEP;
        end else if (diff < -stp) begin
            step_to = cur - STEP;
        end else begin
            step_to = tgt;
        end
    endfunction

    logic signed [8:0] up_tau1, up_tau2, up_phi;
    logic signed [8:0] dn_tau1, dn_tau2, dn_phi;
    logic              ov, ramp_done, outs_zero, vdc_ok;

    assign up_tau1   = step_to(tau1_out, tau1_in);
    assign up_tau2   = step_to(tau2_out, tau2_in);
    assign up_phi    = step_to(phi_out, phi_in);
    assign dn_tau1   = step_to(tau1_out, 9'sd0);
    assign dn_tau2   = step_to(tau2_out, 9'sd0);
    assign dn_phi    = step_to(phi_out, 9'sd0);
    assign ov        = (Vdc1 > VMAX) || (Vdc2 > VMAX);
    assign vdc_ok    = (Vdc1 >= VMIN_START);
    assign ramp_done = (up_tau1 == tau1_in) && (up_tau2 == tau2_in) && (up_phi == phi_in);
    assign outs_zero = (tau1_out == 9'sd0) && (tau2_out == 9'sd0) && (phi_out == 9'sd0);
    assign state     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            tau1_out <= 9'sd0;
            tau2_out <= 9'sd0;
            phi_out  <= 9'sd0;
            gate_en  <= 1'b0;
            fault    <= 1'b0;
        end else if (ov && state_q != StIdle) begin
            state_q  <= StFault;
            cnt_q    <= 4'd0;
            tau1_out <= 9'sd0;
            tau2_out <= 9'sd0;
            phi_out  <= 9'sd0;
            gate_en  <= 1'b0;
            fault    <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    // Over-voltage outranks start even though it cannot trip from here.
                    if (start && !stop && !ov) begin
                        state_q <= StWaitDc;
                        cnt_q   <= 4'd0;
                    end
                end
                StWaitDc: begin
                    if (stop) begin
                        state_q <= StIdle;
                        cnt_q   <= 4'd0;
                    end else if (trigger) begin
                        if (!vdc_ok) begin
                            cnt_q <= 4'd0;
                        end else if (cnt_q == QUAL - 4'd1) begin
                            state_q <= StRamp;
                            cnt_q   <= 4'd0;
                            gate_en <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                StRamp: begin
                    if (stop) begin
                        state_q <= StRampDown;
                    end else if (trigger) begin
                        tau1_out <= up_tau1;
                        tau2_out <= up_tau2;
                        phi_out  <= up_phi;
                        if (ramp_done) state_q <= StRun;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_q <= StRampDown;
                    end else if (trigger) begin
                        tau1_out <= tau1_in;
                        tau2_out <= tau2_in;
                        phi_out  <= phi_in;
                    end
                end
                StRampDown: begin
                    if (outs_zero) begin
                        state_q <= StIdle;
                        gate_en <= 1'b0;
                    end else if (trigger) begin
                        tau1_out <= dn_tau1;
                        tau2_out <= dn_tau2;
                        phi_out  <= dn_phi;
                    end
                end
                StFault: begin
                    if (fault_clr) begin
                        state_q <= StIdle;
                        fault   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    tau1_out <= 9'sd0;
                    tau2_out <= 9'sd0;
                    phi_out  <= 9'sd0;
                    gate_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dab_sequencer.sv
// Scoreboard bench for dab_sequencer: directed scenarios plus random traffic against a
// cycle-level behavioural model; a negedge monitor compares every expected output set.
module tb_dab_sequencer;

    localparam int S_IDLE = 0, S_WAIT = 1, S_RAMP = 2, S_RUN = 3, S_DOWN = 4, S_FAULT = 5;
    localparam int STEP_I = 4, VMIN_I = 1000, VMAX_I = 7000, QUAL_I = 8;

    logic               clk, rst_n, start, stop, fault_clr, trigger;
    logic signed [13:0] vdc1, vdc2;
    logic signed [8:0]  tau1_in, tau2_in, phi_in;
    logic signed [8:0]  tau1_out, tau2_out, phi_out;
    logic               gate_en, fault;
    logic [2:0]         state;

    dab_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .fault_clr (fault_clr),
        .trigger   (trigger),
        .Vdc1      (vdc1),
        .Vdc2      (vdc2),
        .tau1_in   (tau1_in),
        .tau2_in   (tau2_in),
        .phi_in    (phi_in),
        .tau1_out  (tau1_out),
        .tau2_out  (tau2_out),
        .phi_out   (phi_out),
        .gate_en   (gate_en),
        .state     (state),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [8:0] t1;
        logic [8:0] t2;
        logic [8:0] ph;
        logic       g;
        logic       f;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model state
    int m_st, m_cnt, m_t1, m_t2, m_ph, m_gate, m_fault;

    function automatic int toward(int cur, int tgt);
        int d;
        d = tgt - cur;
        if (d > STEP_I) return cur + STEP_I;
        if (d < -STEP_I) return cur - STEP_I;
        return tgt;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_cnt = 0; m_t1 = 0; m_t2 = 0; m_ph = 0; m_gate = 0; m_fault = 0;
    endtask

    task automatic model_step();
        int v1, v2, i1, i2, ip;
        bit over;
        v1 = vdc1; v2 = vdc2; i1 = tau1_in; i2 = tau2_in; ip = phi_in;
        over = (v1 > VMAX_I) || (v2 > VMAX_I);
        if (over && m_st != S_IDLE) begin
            m_st = S_FAULT; m_cnt = 0; m_t1 = 0; m_t2 = 0; m_ph = 0; m_fault = 1;
        end else begin
            case (m_st)
                S_IDLE: if (start && !stop && !over) begin m_st = S_WAIT; m_cnt = 0; end
                S_WAIT: begin
                    if (stop) begin
                        m_st = S_IDLE; m_cnt = 0;
                    end else if (trigger) begin
                        m_cnt = (v1 >= VMIN_I) ? m_cnt + 1 : 0;
                        if (m_cnt == QUAL_I) begin m_st = S_RAMP; m_cnt = 0; end
                    end
                end
                S_RAMP: begin
                    if (stop) m_st = S_DOWN;
                    else if (trigger) begin
                        m_t1 = toward(m_t1, i1); m_t2 = toward(m_t2, i2); m_ph = toward(m_ph, ip);
                        if (m_t1 == i1 && m_t2 == i2 && m_ph == ip) m_st = S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) m_st = S_DOWN;
                    else if (trigger) begin m_t1 = i1; m_t2 = i2; m_ph = ip; end
                end
                S_DOWN: begin
                    if (m_t1 == 0 && m_t2 == 0 && m_ph == 0) m_st = S_IDLE;
                    else if (trigger) begin
                        m_t1 = toward(m_t1, 0); m_t2 = toward(m_t2, 0); m_ph = toward(m_ph, 0);
                    end
                end
                S_FAULT: if (fault_clr) begin m_st = S_IDLE; m_fault = 0; end
                default: m_st = S_IDLE;
            endcase
        end
        m_gate = (m_st == S_RAMP || m_st == S_RUN || m_st == S_DOWN) ? 1 : 0;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.st = 3'(m_st); o.t1 = 9'(m_t1); o.t2 = 9'(m_t2); o.ph = 9'(m_ph);
        o.g = m_gate[0]; o.f = m_fault[0];
        return o;
    endfunction

    // One clock: model predicts the post-edge outputs, monitor checks them at negedge.
    task automatic tick();
        model_step();
        @(posedge clk);
        exp_q.push_back(model_obs());
        #1;
    endtask

    task automatic idle(int n);
        trigger = 1'b0;
        repeat (n) tick();
    endtask

    task automatic trig(int gap);
        idle(gap - 1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic chk(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, tau1_out, tau2_out, phi_out, gate_en, fault};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle @%0t: got st=%0d t1=%0d t2=%0d ph=%0d g=%0d f=%0d, expected st=%0d t1=%0d t2=%0d ph=%0d g=%0d f=%0d",
                         $time, a.st, $signed(a.t1), $signed(a.t2), $signed(a.ph), a.g, a.f,
                         e.st, $signed(e.t1), $signed(e.t2), $signed(e.ph), e.g, e.f);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic start_pulse();
        start = 1'b1; stop = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic go_run();
        tau1_in = 9'sd8; tau2_in = 9'sd4; phi_in = -9'sd4; vdc1 = 14'sd2000; vdc2 = 14'sd2000;
        start_pulse();
        for (int i = 0; i < 200 && m_st != S_RUN; i++) trig(3);
        chk("go_run_state", state, S_RUN);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; fault_clr = 1'b0; trigger = 1'b0;
        vdc1 = '0; vdc2 = '0; tau1_in = '0; tau2_in = '0; phi_in = '0;
        model_reset();
        #3;
        chk("reset_state", state, S_IDLE);
        chk("reset_tau1", tau1_out, 0);
        chk("reset_phi", phi_out, 0);
        chk("reset_gate", gate_en, 0);
        chk("reset_fault", fault, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // start together with stop stays idle
        start = 1'b1; stop = 1'b1;
        idle(5);
        chk("start_stop_idle", state, S_IDLE);

        // Nominal start-up, trigger every 1000 clocks
        stop = 1'b0; vdc1 = 14'sd2000; vdc2 = 14'sd2000;
        phi_in = 9'sd20; tau1_in = 9'sd100; tau2_in = 9'sd100;
        idle(1);
        chk("nom_wait", state, S_WAIT);
        for (int i = 1; i <= 8; i++) begin
            trig(1000);
            if (i == 7) chk("nom_wait7", state, S_WAIT);
        end
        chk("nom_ramp", state, S_RAMP);
        chk("nom_ramp_gate", gate_en, 1);
        for (int i = 1; i <= 25; i++) begin
            trig(1000);
            if (i == 1) begin chk("nom_phi1", phi_out, 4); chk("nom_tau1", tau1_out, 4); end
            if (i == 5) chk("nom_phi5", phi_out, 20);
            if (i == 24) begin chk("nom_st24", state, S_RAMP); chk("nom_tau24", tau2_out, 96); end
        end
        chk("nom_run", state, S_RUN);
        chk("nom_tau_final", tau1_out, 100);
        chk("nom_run_gate", gate_en, 1);

        // Controlled stop from RUN
        phi_in = -9'sd10; tau1_in = 9'sd6; tau2_in = 9'sd6;
        trig(3);
        chk("stop_load_phi", phi_out, -10);
        start = 1'b0; stop = 1'b1;
        idle(2);
        chk("stop_down", state, S_DOWN);
        trig(3);
        chk("stop_phi1", phi_out, -6); chk("stop_tau1", tau1_out, 2);
        trig(3);
        chk("stop_phi2", phi_out, -2); chk("stop_tau2", tau2_out, 0);
        trig(3);
        chk("stop_phi3", phi_out, 0); chk("stop_gate_hold", gate_en, 1);
        idle(1);
        chk("stop_idle", state, S_IDLE); chk("stop_gate_off", gate_en, 0);
        stop = 1'b0;

        // Over-voltage from RUN
        go_run();
        vdc2 = 14'sd7000;
        idle(3);
        chk("ov_edge_run", state, S_RUN);
        vdc2 = 14'sd7001;
        idle(1);
        chk("ov_state", state, S_FAULT); chk("ov_fault", fault, 1);
        chk("ov_gate", gate_en, 0); chk("ov_tau1", tau1_out, 0); chk("ov_phi", phi_out, 0);
        fault_clr = 1'b1;
        idle(4);
        chk("ov_clr_ignored", state, S_FAULT);
        vdc2 = 14'sd5000;
        idle(1);
        chk("ov_clr_idle", state, S_IDLE); chk("ov_clr_fault", fault, 0);
        fault_clr = 1'b0;
        idle(2);

        // Qualification restart
        tau1_in = 9'sd40; tau2_in = 9'sd40; phi_in = 9'sd8;
        start_pulse();
        repeat (5) trig(3);
        vdc1 = 14'sd500;
        trig(3);
        vdc1 = 14'sd2000;
        repeat (7) trig(3);
        chk("qual_7", state, S_WAIT);
        trig(3);
        chk("qual_8", state, S_RAMP);
        stop = 1'b1;
        idle(3);
        chk("qual_stop_idle", state, S_IDLE);
        stop = 1'b0;
        start_pulse();
        vdc1 = -14'sd3000;
        repeat (20) trig(2);
        chk("qual_neg", state, S_WAIT);
        stop = 1'b1; idle(1); stop = 1'b0;
        chk("qual_neg_stop", state, S_IDLE);
        vdc1 = 14'sd2000;

        // Ramp edges: phi 255 -> -256, target changes mid-ramp
        tau1_in = 9'sd0; tau2_in = -9'sd256; phi_in = 9'sd255;
        start_pulse();
        repeat (8) trig(2);
        chk("edge_ramp", state, S_RAMP);
        for (int i = 1; i <= 192; i++) begin
            if (i == 41) tau2_in = 9'sd255;
            if (i == 65) phi_in = -9'sd256;
            trig(2);
            if (i == 64) chk("edge_phi255", phi_out, 255);
            if (i == 65) chk("edge_phi251", phi_out, 251);
            if (i == 191) begin chk("edge_st191", state, S_RAMP); chk("edge_phi191", phi_out, -253); end
        end
        chk("edge_phi_final", phi_out, -256);
        chk("edge_tau2_final", tau2_out, 255);
        chk("edge_run", state, S_RUN);
        stop = 1'b1;
        for (int i = 0; i < 300 && m_st != S_IDLE; i++) trig(2);
        stop = 1'b0;
        chk("edge_down_idle", state, S_IDLE);

        // Asynchronous reset mid-RAMP
        tau1_in = 9'sd100; tau2_in = 9'sd100; phi_in = 9'sd20;
        start_pulse();
        repeat (8) trig(2);
        repeat (3) trig(2);
        chk("ar_pre_tau", tau1_out, 12);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("ar_state", state, S_IDLE); chk("ar_tau1", tau1_out, 0);
        chk("ar_phi", phi_out, 0); chk("ar_gate", gate_en, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        idle(5);
        chk("ar_wait_start", state, S_IDLE);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom % 8) == 0;
            stop      = ($urandom % 48) == 0;
            fault_clr = ($urandom % 16) == 0;
            trigger   = ($urandom % 3) == 0;
            if ($urandom % 12 == 0) vdc1 = 14'(int'($urandom_range(0, 1999)) - 1000);
            else vdc1 = 14'(int'($urandom_range(900, 7000)));
            vdc2 = 14'(int'($urandom_range(0, 7000)));
            if ($urandom % 300 == 0) vdc1 = 14'(int'($urandom_range(7001, 8191)));
            if ($urandom % 300 == 0) vdc2 = 14'(int'($urandom_range(7001, 8191)));
            if ($urandom % 40 == 0) tau1_in = 9'(int'($urandom_range(0, 511)) - 256);
            if ($urandom % 40 == 0) tau2_in = 9'(int'($urandom_range(0, 511)) - 256);
            if ($urandom % 40 == 0) phi_in = 9'(int'($urandom_range(0, 511)) - 256);
            tick();
        end
        start = 1'b0; stop = 1'b0; trigger = 1'b0; fault_clr = 1'b0;
        idle(2);
        @(negedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dab_sequencer.md
DAB_SEQUENCER -- requirements
Module: dab_sequencer

Interface
REQ-001 The block SHALL have parameter STEP, default 9'd4, max change of each modulation output per trigger pulse during ramps.
REQ-002 The block SHALL have parameter VMIN_START, default 14'sd1000, minimum Vdc1 needed to leave WAIT_DC.
REQ-003 The block SHALL have parameter VMAX, default 14'sd7000, over-voltage trip level for Vdc1 and Vdc2.
REQ-004 The block SHALL have parameter QUAL, default 4'd8, number of consecutive qualifying trigger pulses required in WAIT_DC.
REQ-005 The block SHALL have ports, clock and reset first:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level request to start the converter.
- stop  in  1  level request for controlled shutdown.
- fault_clr  in  1  fault acknowledge.
- trigger  in  1  one-cycle pulse per switching period from the modulator.
- Vdc1, Vdc2  in  14 signed  DC-link voltage samples.
- tau1_in, tau2_in, phi_in  in  9 signed  controller modulation targets.
- tau1_out, tau2_out, phi_out  out  9 signed  sequenced values to the modulator.
- gate_en  out  1  switch enable.
- state  out  3  current state code.
- fault  out  1  latched over-voltage flag.

Function
REQ-006 The state machine SHALL have states, with these state codes: IDLE=0, WAIT_DC=1, RAMP=2, RUN=3, RAMPDOWN=4, FAULT=5.
REQ-007 All outputs SHALL be registered.
REQ-008 Modulation outputs SHALL change only in the cycle after a trigger pulse, except on entry to FAULT or IDLE, where they clear to 0 the next cycle.
REQ-009 Event priority SHALL be: over-voltage > stop > start.
REQ-010 Over-voltage SHALL be detected in any cycle, independent of trigger, when Vdc1 > VMAX or Vdc2 > VMAX (signed compare).
- When detected in any state except IDLE, the block SHALL go to FAULT in the next cycle.
- In that same cycle it SHALL set fault=1, gate_en=0, and all outputs=0.
REQ-011 IDLE: outputs 0, gate_en=0.
- start=1 with stop=0 SHALL go to WAIT_DC.
- start=1 with stop=1 SHALL stay in IDLE.
REQ-012 WAIT_DC: gate_en=0.
- A qualification counter SHALL increment on each trigger with Vdc1 >= VMIN_START.
- The counter SHALL clear on a trigger with Vdc1 < VMIN_START; negative Vdc1 counts as below.
- When the count reaches QUAL, the block SHALL go to RAMP.
- stop SHALL return to IDLE and clear the counter.
REQ-013 RAMP: gate_en=1.
- On each trigger, each output SHALL move toward its corresponding *_in by min(|diff|, STEP).
- The difference SHALL be computed in 10-bit signed, so there is no overflow and no overshoot.
- On the trigger where all three outputs equal their inputs after update, the block SHALL go to RUN.
REQ-014 RUN: gate_en=1.
- On each trigger, outputs SHALL load *_in directly.
- Outputs SHALL hold between triggers.
REQ-015 stop=1 in RAMP or RUN SHALL go to RAMPDOWN.
- In RAMPDOWN, each trigger SHALL move every output toward 0 by min(|value|, STEP).
- gate_en SHALL stay 1 until all outputs are 0.
- The block SHALL then go to IDLE, with gate_en=0 in the next cycle.
- start is ignored in RAMPDOWN.
REQ-016 FAULT: outputs 0, gate_en=0, fault=1.
- The block SHALL leave FAULT for IDLE only when fault_clr=1 and both voltages <= VMAX in the same cycle.
- fault SHALL clear in that transition.
REQ-017 A trigger coinciding with a state-changing event SHALL be processed by the destination state's rules from the next trigger onward, not the current one.

Reset
REQ-018 With rst_n=0, asynchronously: state=IDLE, all modulation outputs 0, gate_en=0, fault=0, qualification counter 0.
REQ-019 Reset asserted mid-RAMP or mid-RUN SHALL force those values immediately, with no ramp-down.
REQ-020 After rst_n deasserts, the block SHALL wait for a new start.

Verification
REQ-021 Nominal start: Vdc1=2000, phi_in=20, tau1_in=tau2_in=100, start=1, trigger every 1000 clk.
- Expected: WAIT_DC for 8 triggers.
- Then RAMP with phi_out 4,8,..,20 and tau 4..100 (25 triggers), then RUN, gate_en=1.
REQ-022 Controlled stop from RUN with phi_out=-10, tau=6: stop=1.
- Expected: phi_out -6,-2,0; tau 2,0.
- Then IDLE with gate_en=0 one cycle after all are 0.
REQ-023 Over-voltage: Vdc2=7001 between triggers in RUN.
- Expected: next cycle FAULT, gate_en=0, outputs 0, fault=1.
- fault_clr while Vdc2=7001 SHALL be ignored; fault_clr with Vdc2=5000 SHALL give IDLE.
REQ-024 Qualification: Vdc1 of 2000 for 5 triggers, then 500 for 1 trigger, then 2000.
- Expected: 8 further triggers needed before RAMP.
- Also: Vdc1=-3000 never qualifies.
REQ-025 Ramp edges: phi_in=-256 with phi_out=255.
- Expected: steps of -4 with no overflow, settling exactly at -256.
- With phi_in changing mid-RAMP, the ramp SHALL track the new target.
REQ-026 Async reset during RAMP: expected immediate zero outputs and IDLE without a clock edge.
- Also: start=stop=1 in IDLE SHALL remain IDLE.
